// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note indices (same encoding as
// the buzzer's music_scale input), song entry layout, FSM encoding and the
// default tune.
package melody_pkg;

  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 4;
  localparam int ENTRY_W  = DUR_W + NOTE_W;
  localparam int IDX_W    = 5;
  localparam int SONG_LEN = 22;

  localparam logic [NOTE_W-1:0] REST   = 6'd0;
  localparam logic [NOTE_W-1:0] C_LOW  = 6'd1;
  localparam logic [NOTE_W-1:0] D_LOW  = 6'd2;
  localparam logic [NOTE_W-1:0] E_LOW  = 6'd3;
  localparam logic [NOTE_W-1:0] F_LOW  = 6'd4;
  localparam logic [NOTE_W-1:0] G_LOW  = 6'd5;
  localparam logic [NOTE_W-1:0] A_LOW  = 6'd6;
  localparam logic [NOTE_W-1:0] B_LOW  = 6'd7;
  localparam logic [NOTE_W-1:0] C_MID  = 6'd8;
  localparam logic [NOTE_W-1:0] D_MID  = 6'd9;
  localparam logic [NOTE_W-1:0] E_MID  = 6'd10;
  localparam logic [NOTE_W-1:0] F_MID  = 6'd11;
  localparam logic [NOTE_W-1:0] G_MID  = 6'd12;
  localparam logic [NOTE_W-1:0] A_MID  = 6'd13;
  localparam logic [NOTE_W-1:0] B_MID  = 6'd14;
  localparam logic [NOTE_W-1:0] C_HIGH = 6'd15;
  localparam logic [NOTE_W-1:0] D_HIGH = 6'd16;
  localparam logic [NOTE_W-1:0] E_HIGH = 6'd17;
  localparam logic [NOTE_W-1:0] F_HIGH = 6'd18;
  localparam logic [NOTE_W-1:0] G_HIGH = 6'd19;
  localparam logic [NOTE_W-1:0] A_HIGH = 6'd20;
  localparam logic [NOTE_W-1:0] B_HIGH = 6'd21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Entry = {dur, note}; dur 0 marks the end of the song. Entry 16 carries an
  // out-of-range note index on purpose: it plays as a rest.
  localparam logic [ENTRY_W-1:0] SONG [SONG_LEN] = '{
    {4'd2, C_MID},  {4'd1, REST},   {4'd1, G_MID},  {4'd1, G_MID},
    {4'd1, A_MID},  {4'd1, C_HIGH}, {4'd2, A_MID},  {4'd1, G_MID},
    {4'd1, E_MID},  {4'd1, C_MID},  {4'd1, C_MID},  {4'd1, E_MID},
    {4'd1, G_MID},  {4'd2, G_MID},  {4'd1, E_MID},  {4'd1, E_MID},
    {4'd2, 6'd40},  {4'd1, G_LOW},  {4'd1, C_MID},  {4'd1, G_MID},
    {4'd1, C_HIGH}, {4'd2, C_MID}
  };

  // Indices beyond B_HIGH are not tones the buzzer knows; play silence.
  function automatic logic [NOTE_W-1:0] clamp_note(input logic [NOTE_W-1:0] n);
    return (n > B_HIGH) ? REST : n;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational song table lookup: index -> {dur, note}. Indices at or past
// LENGTH read as an end marker (dur 0).
module melody_rom
  import melody_pkg::*;
#(
  parameter int LENGTH = 22
) (
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DUR_W-1:0]  o_dur,
  output logic [NOTE_W-1:0] o_note
);

  localparam int             LEN_EFF = (LENGTH < SONG_LEN) ? LENGTH : SONG_LEN;
  localparam logic [IDX_W-1:0] LEN_C = IDX_W'(LEN_EFF);

  // table read with out-of-range guard
  always_comb begin
    o_dur  = '0;
    o_note = REST;
    if (i_idx < LEN_C) begin
      {o_dur, o_note} = SONG[i_idx];
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks the song table at BEAT_HZ beats per second and
// drives the buzzer note index. Optional macro MELODY_GAP_EN silences the
// last 1/GAP_DIV of each note's final beat (staccato); default is legato.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BEAT_HZ  = 4,
  parameter int LENGTH   = 22,
  parameter int GAP_DIV  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic [NOTE_W-1:0] o_music_scale,
  output logic              o_playing,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_idx
);

  localparam int TICKS = CLK_FREQ / BEAT_HZ;
  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_TH   = CNT_W'(TICKS - 1 - TICKS / GAP_DIV);
  localparam logic [IDX_W-1:0] LEN_C    = IDX_W'(LENGTH);
`ifdef MELODY_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [DUR_W-1:0]    r_beats, w_beats_nx;
  logic [IDX_W-1:0]    r_idx, w_idx_nx;
  logic [NOTE_W-1:0]   r_note, w_note_nx;
  logic [NOTE_W-1:0]   r_music_scale, w_scale_nx;
  logic                r_playing, w_playing_nx;
  logic                r_done, w_done_nx;
  logic                w_gap;

  logic [IDX_W-1:0]    w_next_idx;
  logic [DUR_W-1:0]    w_next_dur, w_first_dur;
  logic [NOTE_W-1:0]   w_next_note, w_first_note;
  logic                w_tick, w_end;

  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_tick     = (r_cnt == TICK_MAX);
  assign w_end      = (w_next_idx == LEN_C) || (w_next_dur == '0);

  melody_rom #(.LENGTH(LENGTH)) u_rom_next (
    .i_idx  (w_next_idx),
    .o_dur  (w_next_dur),
    .o_note (w_next_note)
  );

  melody_rom #(.LENGTH(LENGTH)) u_rom_first (
    .i_idx  (IDX_W'(0)),
    .o_dur  (w_first_dur),
    .o_note (w_first_note)
  );

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_beats       <= '0;
      r_idx         <= '0;
      r_note        <= REST;
      r_music_scale <= REST;
      r_playing     <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_beats       <= w_beats_nx;
      r_idx         <= w_idx_nx;
      r_note        <= w_note_nx;
      r_music_scale <= w_scale_nx;
      r_playing     <= w_playing_nx;
      r_done        <= w_done_nx;
    end
  end

  // next-state, beat counter and output decode; stop beats start beats FSM
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_beats_nx = r_beats;
    w_idx_nx   = r_idx;
    w_note_nx  = r_note;
    w_done_nx  = 1'b0;
    if (i_stop) begin
      w_state_nx = ST_IDLE;
      w_cnt_nx   = '0;
      w_beats_nx = '0;
      w_idx_nx   = '0;
      w_note_nx  = REST;
    end else if (i_start) begin
      w_cnt_nx = '0;
      w_idx_nx = '0;
      if (w_first_dur == '0) begin
        w_state_nx = ST_DONE;
        w_beats_nx = '0;
        w_note_nx  = REST;
        w_done_nx  = 1'b1;
      end else begin
        w_state_nx = ST_PLAY;
        w_beats_nx = w_first_dur;
        w_note_nx  = clamp_note(w_first_note);
      end
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (!w_tick) begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end else begin
            w_cnt_nx = '0;
            if (r_beats > 4'd1) begin
              w_beats_nx = r_beats - 4'd1;
            end else if (!w_end) begin
              w_idx_nx   = w_next_idx;
              w_beats_nx = w_next_dur;
              w_note_nx  = clamp_note(w_next_note);
            end else if (i_loop) begin
              // seamless wrap: entry 0 starts on the same tick edge
              w_idx_nx   = '0;
              w_beats_nx = w_first_dur;
              w_note_nx  = clamp_note(w_first_note);
            end else begin
              w_state_nx = ST_DONE;
              w_beats_nx = '0;
              w_note_nx  = REST;
              w_done_nx  = 1'b1;
            end
          end
        end
        ST_DONE: w_state_nx = ST_IDLE;
        default: ;
      endcase
    end
    // gap is decided from next-cycle counter so it lines up with the register
    w_gap        = GAP_EN && (w_state_nx == ST_PLAY) && (w_beats_nx == 4'd1) &&
                   (w_cnt_nx > GAP_TH);
    w_scale_nx   = w_gap ? REST : w_note_nx;
    w_playing_nx = (w_state_nx == ST_PLAY);
  end

  assign o_music_scale = r_music_scale;
  assign o_playing     = r_playing;
  assign o_done        = r_done;
  assign o_idx         = r_idx;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer at 20 clocks per beat.
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start, i_stop, i_loop;
  logic [5:0] o_music_scale;
  logic       o_playing, o_done;
  logic [4:0] o_idx;

  int checks   = 0;
  int failures = 0;

`ifdef MELODY_GAP_EN
  localparam logic [31:0] LAST_BEAT_TAIL = 32'd0;
`else
  localparam logic [31:0] LAST_BEAT_TAIL = 32'd8;
`endif

  melody_sequencer #(
    .CLK_FREQ (80),
    .BEAT_HZ  (4),
    .LENGTH   (22),
    .GAP_DIV  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_loop        (i_loop),
    .o_music_scale (o_music_scale),
    .o_playing     (o_playing),
    .o_done        (o_done),
    .o_idx         (o_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic pulse_stop();
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
  endtask

  initial begin
    int done_seen;
    int n_done;
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_loop = 1'b0;
    #1;
    chk("rst_scale", o_music_scale, 0);
    chk("rst_playing", o_playing, 0);
    chk("rst_done", o_done, 0);
    chk("rst_idx", o_idx, 0);
    step(2);
    rst = 1'b0;

    // asynchronous reset in the middle of a cycle while playing
    pulse_start();
    step(5);
    chk("pre_rst_playing", o_playing, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_scale", o_music_scale, 0);
    chk("async_rst_playing", o_playing, 0);
    chk("async_rst_idx", o_idx, 0);
    #1 rst = 1'b0;
    step(50);
    chk("idle_scale", o_music_scale, 0);
    chk("idle_playing", o_playing, 0);
    chk("idle_done", o_done, 0);

    // basic playback: 2 beats of 8, 1 beat rest, then 12
    pulse_start();
    chk("start_scale", o_music_scale, 8);
    chk("start_playing", o_playing, 1);
    chk("start_idx", o_idx, 0);
    step(34);
    chk("c34_scale", o_music_scale, 8);
    step(1);
    chk("c35_scale", o_music_scale, LAST_BEAT_TAIL);
    chk("c35_playing", o_playing, 1);
    step(4);
    chk("c39_scale", o_music_scale, LAST_BEAT_TAIL);
    chk("c39_idx", o_idx, 0);
    step(1);
    chk("c40_scale", o_music_scale, 0);
    chk("c40_idx", o_idx, 1);
    chk("c40_playing", o_playing, 1);
    step(19);
    chk("c59_idx", o_idx, 1);
    step(1);
    chk("c60_scale", o_music_scale, 12);
    chk("c60_idx", o_idx, 2);

    // retrigger at cycle 15 of entry 2
    step(15);
    pulse_start();
    chk("retrig_scale", o_music_scale, 8);
    chk("retrig_idx", o_idx, 0);
    step(39);
    chk("retrig_c39_idx", o_idx, 0);
    step(1);
    chk("retrig_c40_idx", o_idx, 1);
    chk("retrig_c40_scale", o_music_scale, 0);

    // stop mid-note, then start+stop together
    pulse_start();
    step(10);
    pulse_stop();
    chk("stop_scale", o_music_scale, 0);
    chk("stop_playing", o_playing, 0);
    done_seen = 0;
    repeat (60) begin
      step(1);
      if (o_done !== 1'b0) done_seen++;
    end
    chk("stop_no_done", done_seen, 0);
    i_start = 1'b1; i_stop = 1'b1;
    step(1);
    i_start = 1'b0; i_stop = 1'b0;
    chk("both_playing", o_playing, 0);
    chk("both_scale", o_music_scale, 0);
    step(20);
    chk("both_later_playing", o_playing, 0);

    // full song, no loop: 27 beats = 540 cycles, done on cycle 540
    i_loop = 1'b0;
    pulse_start();
    n_done = -1;
    for (int n = 0; n < 600; n++) begin
      if (n == 390) begin
        chk("clamp_scale", o_music_scale, 0);
        chk("clamp_idx", o_idx, 16);
      end
      if (n == 530) begin
        chk("last_scale", o_music_scale, 8);
        chk("last_idx", o_idx, 21);
      end
      if (o_done === 1'b1) begin
        n_done = n;
        chk("done_scale", o_music_scale, 0);
        chk("done_playing", o_playing, 0);
        break;
      end
      step(1);
    end
    chk("done_cycle", n_done, 540);
    step(1);
    chk("done_one_cycle", o_done, 0);
    chk("after_done_playing", o_playing, 0);

    // full song with loop: entry 0 reloads on the final tick edge
    i_loop = 1'b1;
    pulse_start();
    step(530);
    chk("loop_last_idx", o_idx, 21);
    chk("loop_last_scale", o_music_scale, 8);
    step(9);
    chk("loop_c539_idx", o_idx, 21);
    step(1);
    chk("loop_wrap_scale", o_music_scale, 8);
    chk("loop_wrap_idx", o_idx, 0);
    chk("loop_wrap_done", o_done, 0);
    chk("loop_wrap_playing", o_playing, 1);
    step(40);
    chk("loop_second_idx", o_idx, 1);
    i_loop = 1'b0;
    pulse_stop();
    chk("final_stop_playing", o_playing, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Plays a fixed tune by driving the 6-bit note index that the buzzer tone generator consumes (0 = rest, 1..21 = C_LOW..B_HIGH).
- Steps through a song table of {note, duration-in-beats} entries at a tempo of BEAT_HZ beats per second.
- Supports start, stop, retrigger and loop.
- Sits between the game FSM (start/stop/loop control) and the buzzer (o_music_scale to music_scale).

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
BEAT_HZ, 4, beats per second; TICK_MAX = CLK_FREQ/BEAT_HZ - 1
LENGTH, 22, number of song table entries
GAP_DIV, 8, articulation gap is 1/GAP_DIV of a beat; used only with MELODY_GAP_EN

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
i_start  in  1  one-cycle pulse: play from entry 0 (also retriggers while playing)
i_stop  in  1  one-cycle pulse: abort playback
i_loop  in  1  level, sampled at end of song: 1 = restart at entry 0
o_music_scale  out  6  note index to the buzzer
o_playing  out  1  high while in PLAY
o_done  out  1  one-cycle pulse on natural end of song (not looped, not stopped)
o_idx  out  5  current table index

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values: o_music_scale=0, o_playing=0, o_done=0, o_idx=0, beat counter 0, beats_left 0, state IDLE.
- Table entry format: {dur[3:0], note[5:0]}.
  - dur=0 is an end marker; dur 1..15 is the number of beats.
  - note>21 is output as 0 (rest).
- Beat counter: counts 0..TICK_MAX; tick when it equals TICK_MAX, then wraps to 0. Counting runs only in PLAY; the counter clears on every start, retrigger or stop.
- States: IDLE, PLAY, DONE.
- IDLE:
  - i_start sampled at edge N: at edge N+1 idx=0, o_music_scale=note[0], beats_left=dur[0], o_playing=1, state PLAY.
  - If dur[0]=0 (empty song): go to DONE instead.
- PLAY, on tick:
  - beats_left>1: decrement.
  - beats_left==1: next=idx+1.
  - End of song when next==LENGTH or dur[next]==0:
    - i_loop=1: reload entry 0 with no gap cycle and no o_done.
    - i_loop=0: go to DONE; o_music_scale=0, o_playing=0.
  - Otherwise load entry next on that same edge.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- i_stop has the highest priority in any state. Next cycle: IDLE, o_music_scale=0, o_playing=0, no o_done.
- i_start in PLAY or DONE: same as a start from IDLE (entry 0, full first beat).
- i_start and i_stop in the same cycle: stop wins.
- Latency: 1 cycle from control pulse to output change; note boundaries fall exactly at ticks.
- All outputs are registered.

Optional Feature:
MELODY_GAP_EN
- Defined: during the last beat of each note (beats_left==1), o_music_scale=0 while beat counter > TICK_MAX - (TICK_MAX+1)/GAP_DIV. This gives staccato separation. o_playing stays 1.
- Undefined: the note is held for its full duration (legato). GAP_DIV is unused.

Decomposition:
- Package melody_pkg holds:
  - note index constants REST=0, C_LOW=1 ... B_HIGH=21, shared with the buzzer;
  - entry field widths;
  - state encoding;
  - the default song constant table. Its first entries are {dur2,note8}, {dur1,note0}, {dur1,note12}, and entry 21 is the last playable note.
- Sub-module melody_rom: combinational, idx to {dur, note}, contents from melody_pkg.
- The sequencer holds the FSM, beat counter and output registers.

Test Plan:
All tests use CLK_FREQ=80, BEAT_HZ=4 (20 cycles/beat).
1. Assert rst mid-cycle -> immediately o_music_scale=0, o_playing=0, o_done=0, o_idx=0. After release, idle indefinitely with no i_start.
2. i_start pulse -> next cycle o_music_scale=8, o_playing=1 for 40 cycles, then 0 for 20 cycles, then 12. o_idx steps 0,1,2.
3. i_stop at cycle 10 of note 8 -> next cycle o_music_scale=0, o_playing=0, o_done never pulses. Then i_start+i_stop in the same cycle -> remains IDLE.
4. i_loop=0, run to end -> o_done high exactly 1 cycle after the final tick of entry 21, outputs 0. Repeat with i_loop=1 -> o_music_scale=8 on the same edge, o_done stays 0.
5. Retrigger: i_start at cycle 15 of entry 2 -> next cycle o_music_scale=8, o_idx=0, next change exactly 40 cycles later.
6. MELODY_GAP_EN with GAP_DIV=4 -> note 8 output for 35 cycles, then 0 for 5 cycles (o_playing=1), then rest entry for 20 cycles.
